// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller: RAM geometry, flag thresholds and
// the occupancy update opcode.
package fifo_pkg;

  localparam int unsigned RAM_WIDTH_DEF       = 10;
  localparam int unsigned RAM_DEPTH_DEF       = 8;
  localparam int unsigned ADDR_SIZE_DEF       = 3;
  localparam int unsigned ALMOST_FULL_TH_DEF  = 6;
  localparam int unsigned ALMOST_EMPTY_TH_DEF = 2;

  typedef enum logic [1:0] {
    CntHold = 2'd0,
    CntInc  = 2'd1,
    CntDec  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer and RAM-side signal bundle for fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
);
  logic                 push;
  logic                 pop;
  logic [RAM_WIDTH-1:0] data_in;
  logic [RAM_WIDTH-1:0] ram_rd_data;
  logic                 ram_wr_enb;
  logic [ADDR_SIZE-1:0] ram_wr_addr;
  logic [RAM_WIDTH-1:0] ram_data_in;
  logic                 ram_rd_enb;
  logic [ADDR_SIZE-1:0] ram_rd_addr;
  logic [RAM_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   count;
  logic                 error;

  modport slave (
    input  push, pop, data_in, ram_rd_data,
    output ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr,
           data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

  modport master (
    output push, pop, data_in, ram_rd_data,
    input  ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr,
           data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

endinterface

// File: rtl/fifo_ptr.sv
// Enable-driven wrapping address counter (0 .. DEPTH-1) with async
// active-high reset; used for both FIFO pointers.
module fifo_ptr #(
  parameter int unsigned ADDR_SIZE = 3,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  output logic [ADDR_SIZE-1:0] o_ptr
);

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(DEPTH - 1);

  logic [ADDR_SIZE-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM.
// Define FIFO_CTRL_ERR_EN to enable the sticky overflow/underflow error flag.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned RAM_WIDTH       = RAM_WIDTH_DEF,
  parameter int unsigned RAM_DEPTH       = RAM_DEPTH_DEF,
  parameter int unsigned ADDR_SIZE       = ADDR_SIZE_DEF,
  parameter int unsigned ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
  parameter int unsigned ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned CW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [ADDR_SIZE:0] AE_C    = CW'(ALMOST_EMPTY_TH);

  logic                 w_push_acc;
  logic                 w_pop_acc;
  cnt_op_e              w_cnt_op;
  logic [ADDR_SIZE:0]   w_count_nxt;
  logic [ADDR_SIZE-1:0] w_wr_ptr;
  logic [ADDR_SIZE-1:0] w_rd_ptr;

  logic [ADDR_SIZE:0]   r_count;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_almost_full;
  logic                 r_almost_empty;
  logic                 r_rd_pend;
  logic                 r_valid;
  logic [RAM_WIDTH-1:0] r_data;

  // A pop frees the slot the simultaneous push needs; pops never see same-cycle pushes.
  assign w_pop_acc  = !rst && bus.pop && !r_empty;
  assign w_push_acc = !rst && bus.push && (!r_full || w_pop_acc);

  fifo_ptr #(
    .ADDR_SIZE(ADDR_SIZE),
    .DEPTH    (RAM_DEPTH)
  ) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_push_acc),
    .o_ptr(w_wr_ptr)
  );

  fifo_ptr #(
    .ADDR_SIZE(ADDR_SIZE),
    .DEPTH    (RAM_DEPTH)
  ) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pop_acc),
    .o_ptr(w_rd_ptr)
  );

  always_comb begin
    w_cnt_op = CntHold;
    if (w_push_acc && !w_pop_acc) begin
      w_cnt_op = CntInc;
    end else if (w_pop_acc && !w_push_acc) begin
      w_cnt_op = CntDec;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case (w_cnt_op)
      CntInc:  w_count_nxt = r_count + 1'b1;
      CntDec:  w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_empty        <= (w_count_nxt == '0);
      r_full         <= (w_count_nxt == DEPTH_C);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_almost_empty <= (w_count_nxt <= AE_C);
    end
  end

  // RAM output is valid the edge after the read; capture it one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_pend <= w_pop_acc;
      r_valid   <= r_rd_pend;
      if (r_rd_pend) begin
        r_data <= bus.ram_rd_data;
      end
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if ((bus.push && !w_push_acc) || (bus.pop && !w_pop_acc)) begin
      r_error <= 1'b1;
    end
  end

  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.ram_wr_enb   = w_push_acc;
  assign bus.ram_wr_addr  = w_wr_ptr;
  assign bus.ram_data_in  = bus.data_in;
  assign bus.ram_rd_enb   = w_pop_acc;
  assign bus.ram_rd_addr  = w_rd_ptr;
  assign bus.data_out     = r_data;
  assign bus.valid_out    = r_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.count        = r_count;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: behavioural RAM, queue-based reference
// model, directed and randomized push/pop sequences.
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_ctrl_if #(.RAM_WIDTH(10), .ADDR_SIZE(3)) bus ();

  fifo_ctrl #(
    .RAM_WIDTH      (10),
    .RAM_DEPTH      (8),
    .ADDR_SIZE      (3),
    .ALMOST_FULL_TH (6),
    .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural RAM: registered read, old data on same-address write.
  logic [9:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_wr_enb) mem[bus.ram_wr_addr] <= bus.ram_data_in;
    if (bus.ram_rd_enb) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [9:0] q[$];
  int         wr_tot = 0;
  int         rd_tot = 0;
  logic       pend_v = 1'b0;
  logic [9:0] pend_d = '0;
  logic [9:0] exp_data = '0;
  logic       exp_valid = 1'b0;
  logic       exp_err = 1'b0;
  int         max_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = q.size();
    chk("count", 32'(bus.count), n);
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == 8));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    chk("valid_out", 32'(bus.valid_out), 32'(exp_valid));
    chk("data_out", 32'(bus.data_out), 32'(exp_data));
    chk("error", 32'(bus.error), 32'(exp_err));
  endtask

  task automatic step(input logic ps, input logic pp, input logic [9:0] d);
    logic       pa, wa;
    logic [9:0] popped;
    popped = '0;
    @(negedge clk);
    bus.push = ps;
    bus.pop = pp;
    bus.data_in = d;
    #1;
    pa = pp && (q.size() != 0);
    wa = ps && ((q.size() < 8) || pa);
    chk("ram_wr_enb", 32'(bus.ram_wr_enb), 32'(wa));
    chk("ram_rd_enb", 32'(bus.ram_rd_enb), 32'(pa));
    if (wa) begin
      chk("ram_wr_addr", 32'(bus.ram_wr_addr), wr_tot % 8);
      chk("ram_data_in", 32'(bus.ram_data_in), 32'(d));
    end
    if (pa) chk("ram_rd_addr", 32'(bus.ram_rd_addr), rd_tot % 8);
    @(posedge clk);
    #1;
    if (pa) begin
      popped = q.pop_front();
      rd_tot++;
    end
    if (wa) begin
      q.push_back(d);
      wr_tot++;
    end
`ifdef FIFO_CTRL_ERR_EN
    if ((ps && !wa) || (pp && !pa)) exp_err = 1'b1;
`endif
    exp_valid = pend_v;
    if (pend_v) exp_data = pend_d;
    pend_v = pa;
    pend_d = popped;
    if (q.size() > max_cnt) max_cnt = q.size();
    chk_state();
  endtask

  task automatic model_reset();
    q.delete();
    wr_tot = 0;
    rd_tot = 0;
    pend_v = 1'b0;
    exp_valid = 1'b0;
    exp_data = '0;
    exp_err = 1'b0;
  endtask

  initial begin
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.data_in = 10'h155;
    // Reset values and RAM enables held low while rst is high
    #12;
    chk("rst_wr_enb", 32'(bus.ram_wr_enb), 0);
    chk("rst_rd_enb", 32'(bus.ram_rd_enb), 0);
    chk("rst_wr_addr", 32'(bus.ram_wr_addr), 0);
    chk("rst_rd_addr", 32'(bus.ram_rd_addr), 0);
    chk_state();
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop = 1'b0;
    rst = 1'b0;

    // Basic two-word round trip
    step(1, 0, 10'h0FF);
    step(1, 0, 10'h0CC);
    step(0, 1, 10'h000);
    step(0, 1, 10'h000);
    step(0, 0, 10'h000);
    chk("rt_first_or_second", 32'(bus.data_out), 32'h0CC);
    step(0, 0, 10'h000);

    // Fill to full, overflow, then simultaneous push/pop at full
    for (int i = 1; i <= 8; i++) step(1, 0, 10'(i));
    step(1, 0, 10'h009);
    step(1, 1, 10'h3AA);
    chk("full_pp_count", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) step(0, 1, 10'h000);
    step(0, 0, 10'h000);
    chk("last_word_3aa", 32'(bus.data_out), 32'h3AA);

    // Underflow, and pop rejected alongside a push on empty
    step(0, 1, 10'h000);
    step(1, 1, 10'h123);
    step(0, 1, 10'h000);
    step(0, 0, 10'h000);
    step(0, 0, 10'h000);

    // Streaming 20 words through the wrap point
    max_cnt = 0;
    step(1, 0, 10'h200);
    for (int i = 1; i < 20; i++) step(1, 1, 10'(10'h200 + i));
    step(0, 1, 10'h000);
    step(0, 0, 10'h000);
    step(0, 0, 10'h000);
    chk("stream_max_cnt", 32'(max_cnt <= 2), 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
    end
    while (q.size() != 0) step(0, 1, 10'h000);
    step(0, 0, 10'h000);
    step(0, 0, 10'h000);

    // Asynchronous reset mid-stream with five words queued
    for (int i = 0; i < 5; i++) step(1, 0, 10'(10'h050 + i));
    step(1, 1, 10'h05F);
    chk("pre_rst_count", 32'(bus.count), 5);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_wr_addr", 32'(bus.ram_wr_addr), 0);
    chk("arst_rd_addr", 32'(bus.ram_rd_addr), 0);
    chk("arst_wr_enb", 32'(bus.ram_wr_enb), 0);
    chk("arst_rd_enb", 32'(bus.ram_rd_enb), 0);
    chk_state();
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop = 1'b0;
    rst = 1'b0;

    // Operation restarts from address 0 after reset
    step(1, 0, 10'h2A5);
    step(0, 1, 10'h000);
    step(0, 0, 10'h000);
    step(0, 0, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller driving the dual-port RAM (write port wr_enb/wr_addr/data_in, read port rd_enb/rd_addr/data_out) from the producer/consumer side. Converts push/pop requests into RAM enables and wrapping addresses, tracks occupancy, and returns read data with a valid strobe. It sits between the PCIe lane logic and the RAM macro, replacing bench-driven RAM control in the datapath.

## Interface
- RAM_WIDTH, 10, data word width
- RAM_DEPTH, 8, number of RAM entries (power of two)
- ADDR_SIZE, 3, log2(RAM_DEPTH)
- ALMOST_FULL_TH, 6, almost_full asserts when count >= this
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- push  in  1  write request, data_in sampled same edge
- pop  in  1  read request
- data_in  in  RAM_WIDTH  word to store
- ram_rd_data  in  RAM_WIDTH  RAM read-port output, valid one cycle after ram_rd_enb
- ram_wr_enb  out  1  RAM write enable (combinational from accepted push)
- ram_wr_addr  out  ADDR_SIZE  RAM write address (= write pointer)
- ram_data_in  out  RAM_WIDTH  RAM write data (= data_in)
- ram_rd_enb  out  1  RAM read enable (combinational from accepted pop)
- ram_rd_addr  out  ADDR_SIZE  RAM read address (= read pointer)
- data_out  out  RAM_WIDTH  registered read data
- valid_out  out  1  data_out valid, one-cycle pulse per accepted pop
- full, empty, almost_full, almost_empty  out  1 each  status flags, registered
- count  out  ADDR_SIZE+1  current occupancy, 0..RAM_DEPTH
- error  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Pointers wr_ptr, rd_ptr are ADDR_SIZE bits, wrap RAM_DEPTH-1 -> 0; count is separate ADDR_SIZE+1-bit register.
- push accepted iff push && (!full || pop_accepted); pop accepted iff pop && !empty. No fall-through: pop on empty is rejected even with simultaneous push.
- Accepted push: ram_wr_enb=1, wr_ptr++ next edge. Accepted pop: ram_rd_enb=1, rd_ptr++ next edge.
- count: +1 push only, -1 pop only, unchanged on both or neither.
- Flags derived from next count and registered: empty=(count==0), full=(count==RAM_DEPTH), thresholds inclusive.
- Rejected push (full, no pop) = overflow; rejected pop (empty) = underflow; state unchanged, RAM enables stay 0.
- Reset values: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, valid_out=0, data_out=0, error=0; ram_wr_enb/ram_rd_enb=0 while rst high.
- Reset mid-operation discards contents; RAM not cleared, pointers simply restart at 0.

## Timing
- Write: push at edge N -> word in RAM at edge N, visible to a pop issued at edge N+1.
- Read latency: pop accepted at edge N -> RAM reads at N, data_out/valid_out registered at N+1 (pop-to-data 2 edges; ram_rd_data captured at N+1).
- Back-to-back pops every cycle sustain one word per cycle.
- Flags and count update on the same edge as the pointer change.

## Configuration
- FIFO_CTRL_ERR_EN defined: error sets on any overflow or underflow, holds until rst.
- Not defined: error tied 0, no detection logic; push/pop rejection behaviour unchanged.

## Structure
- Package fifo_pkg: default RAM_WIDTH/RAM_DEPTH/ADDR_SIZE constants, threshold defaults.
- One sub-module fifo_ptr (enable-driven wrapping ADDR_SIZE counter with async reset), instantiated for write and read pointers.

## Test plan
- Reset, push 0x0FF then 0x0CC, pop twice -> data_out 0x0FF then 0x0CC with valid_out pulses 2 edges after each pop; empty=1 after.
- Push 8 words 0x001..0x008 -> full=1 at 8th, almost_full from 6th; 9th push rejected, count stays 8, error=1 (with FIFO_CTRL_ERR_EN).
- Full FIFO, push 0x3AA and pop same cycle -> both accepted, count 8, data_out 0x001 then later 0x3AA read last.
- Empty FIFO, pop -> no ram_rd_enb, no valid_out, error=1; pop with simultaneous push -> pop rejected, count 1.
- Push/pop 20 words streaming -> pointers wrap 7->0, output order equals input order, count never exceeds 2.
- Assert rst asynchronously mid-stream with count=5 -> count 0, empty=1, valid_out=0 immediately, pointers 0.
